// File: rtl/mips_int_ctrl.sv
// Interrupt controller feeding CP0 HWInt; INTC_EDGE_EN adds per-source edge mode (MODE reg).
// Latency: dev_int to HWInt 1 cycle; register reads combinational, writes land on next edge.
// Backpressure: none; int_ack arriving while busy is dropped and flagged in STATUS.OVR.
module mips_int_ctrl #(
  parameter int N_SRC   = 6,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] dev_int,
  input  logic [2:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic [5:0]       HWInt,
  output logic             busy
);

  typedef enum logic {IDLE, IN_SERVICE} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [N_SRC-1:0] mask, pend, eligible, hi_mask, vis, retire_oh;
  logic [2:0]       id, sel_id;
  logic [31:0]      cnt;
  logic             to_flag, ovr_flag;
  logic             take, retire, to_hit, ovr_set;
  logic             wr_mask, wr_pend, wr_eoi, wr_stat;
  logic [5:0]       hw_full;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];

  assign wr_mask = we && (addr == 3'd0);
  assign wr_pend = we && (addr == 3'd1);
  assign wr_eoi  = we && (addr == 3'd2);
  assign wr_stat = we && (addr == 3'd3);

  assign eligible = pend & mask;
  assign busy     = (state == IN_SERVICE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    retire    = 1'b0;
    to_hit    = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (int_ack && (|eligible)) begin
          take      = 1'b1;
          state_nxt = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        ovr_set = int_ack;
        if (wr_eoi) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          retire    = 1'b1;
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lowest set index wins, so scan downward and let later hits overwrite.
  always_comb begin
    sel_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (eligible[i]) sel_id = 3'(i);
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      hi_mask[i]   = (i < int'(id));
      retire_oh[i] = retire && (int'(id) == i);
    end
    vis                  = busy ? (eligible & hi_mask) : eligible;
    hw_full              = '0;
    hw_full[N_SRC-1:0]   = vis;
  end

  assign HWInt = hw_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      id       <= 3'd0;
      cnt      <= '0;
      to_flag  <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      if (wr_mask) mask <= wdata[N_SRC-1:0];
      if (take) begin
        id  <= sel_id;
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + 32'd1;
      end
      to_flag  <= (to_flag  && !wr_stat) || to_hit;
      ovr_flag <= (ovr_flag && !wr_stat) || ovr_set;
    end
  end

`ifdef INTC_EDGE_EN
  logic [N_SRC-1:0] mode, dev_q, pend_clr;

  assign pend_clr = (wr_pend ? wdata[N_SRC-1:0] : '0) | retire_oh;

  // Edge sources: a new rising edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode  <= '0;
      dev_q <= '0;
      pend  <= '0;
    end else begin
      if (we && (addr == 3'd4)) mode <= wdata[N_SRC-1:0];
      dev_q <= dev_int;
      for (int i = 0; i < N_SRC; i++)
        pend[i] <= mode[i] ? ((pend[i] && !pend_clr[i]) || (dev_int[i] && !dev_q[i]))
                           : dev_int[i];
    end
  end
`else
  logic unused_edge;

  assign unused_edge = wr_pend ^ (|retire_oh);

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= dev_int;
  end
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata[N_SRC-1:0] = mask;
      3'd1: rdata[N_SRC-1:0] = pend;
      3'd3: rdata = {busy, to_flag, ovr_flag, 26'b0, id};
`ifdef INTC_EDGE_EN
      3'd4: rdata[N_SRC-1:0] = mode;
`endif
      default: rdata = '0;
    endcase
  end

endmodule
